// File: rtl/vga_box_painter_pkg.sv
// Shared VGA definitions: active-area defaults, run/pause encodings and box geometry helpers.
// Imported by the box painter and its button front end.
package vga_box_painter_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_OFF   = 3'b000;
  localparam rgb_t RGB_BLANK = 3'b111;
  localparam rgb_t RGB_RUN   = 3'b100;
  localparam rgb_t RGB_PAUSE = 3'b010;
  localparam rgb_t RGB_BG    = 3'b001;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
  } axis_t;

  // start <= pos < start + size, evaluated on 11 bits so the upper bound never wraps
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] start,
                                   input logic [COORD_W:0]   size);
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    lo = {1'b0, start};
    hi = lo + size;
    return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  // One frame of motion on one axis, bouncing between 0 and limit
  function automatic axis_t axis_advance(input axis_t            cur,
                                         input logic [COORD_W:0] step,
                                         input logic [COORD_W:0] limit);
    axis_t nxt;
    nxt = cur;
    if (cur.dir) begin
      if (({1'b0, cur.pos} + step) >= limit) begin
        nxt.pos = limit[COORD_W-1:0];
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = cur.pos + step[COORD_W-1:0];
        nxt.dir = 1'b1;
      end
    end else begin
      if ({1'b0, cur.pos} <= step) begin
        nxt.pos = {COORD_W{1'b0}};
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = cur.pos - step[COORD_W-1:0];
        nxt.dir = 1'b0;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_box_painter_button_debounce.sv
// Push-button front end: two-flop synchronizer, level debounce and a one-cycle press pulse
// on each accepted high-to-low transition of the active-low button.
module button_debounce
  import vga_box_painter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);
  assign press     = r_press;

  // Synchronize the raw button into the clk_sys domain; idle level is released (high)
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles the synchronized input disagrees with the accepted level
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_level <= 1'b1;
      r_cnt   <= {CNT_W{1'b0}};
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && !r_sync2;
      if (!w_differs) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_box_painter.sv
// Bouncing-box painter: a square moves one step per frame and bounces off the visible edges;
// the push button pauses/resumes motion, and the box colour reflects the run state.
module vga_box_painter
  import vga_box_painter_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int BOX_SIZE        = 40,
  parameter int STEP            = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               display_en,
  input  logic [COORD_W-1:0] h_count,
  input  logic [COORD_W-1:0] v_count,
  input  logic               button,
  output logic               r0,
  output logic               g0,
  output logic               b0,
  output logic               paused
);

  localparam logic [COORD_W:0] X_LIMIT = (COORD_W + 1)'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0] Y_LIMIT = (COORD_W + 1)'(V_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0] STEP_W  = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W:0] BOX_W   = (COORD_W + 1)'(BOX_SIZE);
  localparam logic [COORD_W:0] V_TICK  = (COORD_W + 1)'(V_ACTIVE);

  logic [COORD_W-1:0] r_box_x;
  logic [COORD_W-1:0] r_box_y;
  logic               r_dx;
  logic               r_dy;
  run_state_e         r_state;
  logic               r_paused;
  rgb_t               r_rgb;

  logic               w_press;
  logic               w_frame_tick;
  logic               w_in_box;
  axis_t              w_x_next;
  axis_t              w_y_next;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_sys(clk_sys),
    .reset  (reset),
    .button (button),
    .press  (w_press)
  );

  // First pixel of the first blanked line marks the frame boundary
  assign w_frame_tick = (h_count == {COORD_W{1'b0}}) && ({1'b0, v_count} == V_TICK);

  assign w_x_next = axis_advance(axis_t'({r_box_x, r_dx}), STEP_W, X_LIMIT);
  assign w_y_next = axis_advance(axis_t'({r_box_y, r_dy}), STEP_W, Y_LIMIT);

  assign w_in_box = in_span(h_count, r_box_x, BOX_W) && in_span(v_count, r_box_y, BOX_W);

  assign r0     = r_rgb.r;
  assign g0     = r_rgb.g;
  assign b0     = r_rgb.b;
  assign paused = r_paused;

  // Run/pause FSM and box motion; motion looks at the state before any same-cycle toggle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_box_x  <= {COORD_W{1'b0}};
      r_box_y  <= {COORD_W{1'b0}};
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
      r_state  <= ST_RUN;
      r_paused <= 1'b0;
    end else begin
      if (w_frame_tick && (r_state == ST_RUN)) begin
        r_box_x <= w_x_next.pos;
        r_dx    <= w_x_next.dir;
        r_box_y <= w_y_next.pos;
        r_dy    <= w_y_next.dir;
      end
      if (w_press) begin
        case (r_state)
          ST_RUN: begin
            r_state  <= ST_PAUSE;
            r_paused <= 1'b1;
          end
          ST_PAUSE: begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
          end
          default: begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel colour, one cycle behind the timing inputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rgb <= RGB_OFF;
    end else if (!display_en) begin
      r_rgb <= RGB_BLANK;
    end else if (w_in_box) begin
      case (r_state)
        ST_RUN:   r_rgb <= RGB_RUN;
        ST_PAUSE: r_rgb <= RGB_PAUSE;
        default:  r_rgb <= RGB_RUN;
      endcase
    end else begin
      r_rgb <= RGB_BG;
    end
  end

endmodule
